// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle MIPS-style datapath: sequences fetch,
// decode, and the per-class execute/memory/write-back steps and drives datapath selects.
module multicycle_control_unit #(
  parameter int unsigned OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           Zero,
  output logic           IorD,
  output logic           IRWrite,
  output logic           MemWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           ExtSel,
  output logic           PCEn,
  output logic [3:0]     State,
  output logic           Illegal
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  state_e state_q, state_d;
  // Low from reset until the first clock edge after release; gates every enable.
  logic   run_q;
  logic   is_logi;
  logic   unused_funct;

  assign is_logi      = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
  assign unused_funct = ^Funct;
  assign State        = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    ExtSel   = 1'b0;
    PCEn     = 1'b0;
    Illegal  = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          state_d = S_DECODE;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCEn    = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          if ((Opcode == OP_LW) || (Opcode == OP_SW))                state_d = S_MEMADR;
          else if (Opcode == OP_RTYPE)                               state_d = S_RTYPEEX;
          else if ((Opcode == OP_BEQ) || (Opcode == OP_BNE))         state_d = S_BRANCH;
          else if ((Opcode == OP_ADDI) || is_logi)                   state_d = S_IMMEX;
          else if (Opcode == OP_J)                                   state_d = S_JUMP;
          else                                                       Illegal = 1'b1;
        end
        S_MEMADR: begin
          state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          state_d = S_MEMWB;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_RTYPEEX: begin
          state_d = S_ALUWB;
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        // Logical immediates zero-extend and bypass funct decode.
        S_IMMEX: begin
          state_d = S_IMMWB;
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = is_logi ? 2'b11 : 2'b00;
          ExtSel  = is_logi;
        end
        S_IMMWB: begin
          RegWrite = 1'b1;
          ExtSel   = is_logi;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          PCEn    = (Opcode == OP_BNE) ? ~Zero : Zero;
        end
        S_JUMP: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle control
// word sequence; a negedge monitor pops and compares one entry per cycle.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       ExtSel, PCEn, Illegal;
  logic [3:0] State;

  multicycle_control_unit #(.OPW(6)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .ExtSel(ExtSel),
    .PCEn(PCEn), .State(State), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       extsel, pcen, illegal;
  } exp_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_ADDI = 3, C_LOGI = 4,
                 C_BEQ = 5, C_BNE = 6, C_J = 7, C_ILL = 8;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b001000: return C_ADDI;
      6'b001100, 6'b001101: return C_LOGI;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  task automatic chk(input string name, input exp_t e);
    exp_t a;
    a = {State, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
         ALUSrcB, ALUOp, PCSrc, ExtSel, PCEn, Illegal};
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL %s op=%b zero=%b: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, Opcode, Zero, a.st, a[15:0], e.st, e[15:0]);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_cycle", e);
    end
  end

  // Builds the instruction's control microprogram step by step.
  task automatic build(input logic [5:0] op, input logic z, output exp_t seq[$]);
    exp_t e;
    int   c;
    c = classify(op);
    seq.delete();
    e = '0; e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; seq.push_back(e);
    e = '0; e.st = 1; e.alusrcb = 2'b11; e.illegal = (c == C_ILL); seq.push_back(e);
    case (c)
      C_LW, C_SW: begin
        e = '0; e.st = 2; e.alusrca = 1; e.alusrcb = 2'b10; seq.push_back(e);
        if (c == C_LW) begin
          e = '0; e.st = 3; e.iord = 1; seq.push_back(e);
          e = '0; e.st = 4; e.memtoreg = 1; e.regwrite = 1; seq.push_back(e);
        end else begin
          e = '0; e.st = 5; e.iord = 1; e.memwrite = 1; seq.push_back(e);
        end
      end
      C_R: begin
        e = '0; e.st = 6; e.alusrca = 1; e.aluop = 2'b10; seq.push_back(e);
        e = '0; e.st = 7; e.regdst = 1; e.regwrite = 1; seq.push_back(e);
      end
      C_ADDI, C_LOGI: begin
        e = '0; e.st = 9; e.alusrca = 1; e.alusrcb = 2'b10;
        e.aluop = (c == C_LOGI) ? 2'b11 : 2'b00; e.extsel = (c == C_LOGI); seq.push_back(e);
        e = '0; e.st = 10; e.regwrite = 1; e.extsel = (c == C_LOGI); seq.push_back(e);
      end
      C_BEQ, C_BNE: begin
        e = '0; e.st = 8; e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
        e.pcen = (c == C_BEQ) ? z : ~z; seq.push_back(e);
      end
      C_J: begin
        e = '0; e.st = 11; e.pcsrc = 2'b10; e.pcen = 1; seq.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at negedge+2 of the last kept step.
  task automatic run_instr(input logic [5:0] op, input logic z, input int keep);
    exp_t seq[$];
    int   n;
    build(op, z, seq);
    n = (keep <= 0 || keep > seq.size()) ? seq.size() : keep;
    Opcode = op;
    Zero   = z;
    Funct  = 6'($urandom);
    for (int i = 0; i < n; i++) sb.push_back(seq[i]);
    repeat (n - 1) begin @(posedge CLK); #1; end
    @(negedge CLK); #2;
  endtask

  task automatic instr(input logic [5:0] op, input logic z);
    run_instr(op, z, 0);
    @(posedge CLK); #1;
  endtask

  // Asserts reset mid-cycle, checks suppression, releases; returns at posedge+1 of first FETCH.
  task automatic apply_reset();
    exp_t zero_e;
    zero_e = '0;
    RST = 1'b1;
    #1 chk("rst_async", zero_e);
    @(posedge CLK); #1 chk("rst_held", zero_e);
    @(negedge CLK); RST = 1'b0;
    #1 chk("rst_released_pre_edge", zero_e);
    @(posedge CLK); #1;
  endtask

  logic [5:0] legal_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
                                6'b001101, 6'b000100, 6'b000101, 6'b000010};

  initial begin
    logic [5:0] op;
    exp_t       seq[$];
    #2;
    apply_reset();
    instr(6'b100011, 1'($urandom));
    instr(6'b000100, 1'b1);
    instr(6'b000101, 1'b1);
    instr(6'b000100, 1'b0);
    instr(6'b001101, 1'b0);
    instr(6'b001000, 1'b1);
    instr(6'b001100, 1'b0);
    instr(6'b111111, 1'b0);
    instr(6'b000000, 1'b0);
    instr(6'b101011, 1'b0);
    instr(6'b000010, 1'b0);
    // Reset landing in MEMWR must kill the store immediately.
    run_instr(6'b101011, 1'b0, 4);
    apply_reset();
    run_instr(6'b100011, 1'b0, 4);
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 8)];
      else op = 6'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        build(op, 1'b0, seq);
        run_instr(op, 1'($urandom), $urandom_range(1, seq.size()));
        apply_reset();
      end else begin
        instr(op, 1'($urandom));
      end
    end
    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPW, default 6, meaning opcode/funct field width.
REQ-002 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Opcode, input, OPW, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port Funct, input, OPW, instruction bits [5:0].
REQ-006 SHALL have port Zero, input, 1, ALU zero flag.
REQ-007 SHALL have ports IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, output, 1 each, standard multicycle datapath selects/enables.
REQ-008 SHALL have ports ALUSrcB, ALUOp, PCSrc, output, 2 each; ALUOp 00=add, 01=sub, 10=funct, 11=logical-imm (Funct ignored).
REQ-009 SHALL have port ExtSel, output, 1; 0=sign-extend immediate, 1=zero-extend (drives extension unit).
REQ-010 SHALL have port PCEn, output, 1, PC write enable.
REQ-011 SHALL have ports State, output, 4, current state; Illegal, output, 1, one-cycle unsupported-opcode flag.

Function
REQ-012 SHALL be a Moore FSM, registered state, outputs decoded combinationally from State (PCEn also from Zero/Opcode).
REQ-013 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all enables 0.
REQ-014 SHALL transition FETCH->DECODE unconditionally.
REQ-015 SHALL transition from DECODE by Opcode: 100011 (LW)/101011 (SW)->MEMADR; 000000->RTYPEEX; 000100 (BEQ)/000101 (BNE)->BRANCH; 001000 (ADDI)/001100 (ANDI)/001101 (ORI)->IMMEX; 000010 (J)->JUMP; other->FETCH with Illegal=1 that DECODE cycle.
REQ-016 SHALL transition MEMADR->MEMRD for LW, ->MEMWR for SW; MEMRD->MEMWB; RTYPEEX->ALUWB; IMMEX->IMMWB; MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP->FETCH.
REQ-017 FETCH SHALL assert IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCEn=1.
REQ-018 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtSel=0 (branch target).
REQ-019 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtSel=0; MEMRD IorD=1; MEMWR IorD=1, MemWrite=1; MEMWB RegDst=0, MemtoReg=1, RegWrite=1.
REQ-020 RTYPEEX SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=10; ALUWB RegDst=1, MemtoReg=0, RegWrite=1.
REQ-021 IMMEX SHALL assert ALUSrcA=1, ALUSrcB=10; ADDI: ALUOp=00, ExtSel=0; ANDI/ORI: ALUOp=11, ExtSel=1; IMMWB RegDst=0, MemtoReg=0, RegWrite=1, ExtSel held as in IMMEX.
REQ-022 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01; PCEn=Zero for BEQ, ~Zero for BNE.
REQ-023 JUMP SHALL assert PCSrc=10, PCEn=1.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 Each instruction latency SHALL be: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3, illegal 2 cycles.

Reset
REQ-026 RST=1 SHALL force State=FETCH immediately (asynchronously), at any state including mid-instruction; no partial write-back completes after assertion.
REQ-027 During RST=1 all outputs except State SHALL be 0 (PCEn, IRWrite, RegWrite, MemWrite suppressed); first FETCH outputs appear in the cycle after the first rising CLK with RST=0.

Verification
REQ-028 LW (100011) after reset -> State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-029 BEQ with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH; BNE with Zero=1 -> PCEn=0 in BRANCH; both return to FETCH.
REQ-030 ORI (001101) -> ExtSel=1, ALUOp=11 in IMMEX and ExtSel=1 in IMMWB; ADDI -> ExtSel=0 throughout.
REQ-031 Opcode 111111 in DECODE -> Illegal=1 for one cycle, next State=0, no RegWrite/MemWrite asserted.
REQ-032 RST pulsed asynchronously during MEMWR -> State=0 before next CLK edge, MemWrite drops to 0 immediately.
REQ-033 Back-to-back R-type, SW, J sequence -> total 11 cycles, PCEn=1 in each FETCH and in JUMP only.
